// File: rtl/ray_dispatcher_pkg.sv
// Shared types and default sizing for the ray dispatcher and its arbiter.
package ray_dispatcher_pkg;

  localparam int NUM_UNITS_DEF      = 4;
  localparam int POSITION_WIDTH_DEF = 16;
  localparam int ADDRESS_WIDTH_DEF  = 32;
  localparam int COUNT_WIDTH_DEF    = 24;

  typedef logic signed [2:0][POSITION_WIDTH_DEF-1:0] vec_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    RUN    = 2'd2,
    DONE   = 2'd3
  } dispatch_state_e;

endpackage

// File: rtl/ray_dispatcher_if.sv
// Frame control, generator handshake and ray-unit issue bus of the dispatcher.
interface ray_dispatcher_if #(
  parameter int NUM_UNITS      = 4,
  parameter int POSITION_WIDTH = 16,
  parameter int ADDRESS_WIDTH  = 32,
  parameter int COUNT_WIDTH    = 24
);
  logic                                  frameStart;
  logic                                  busy;
  logic                                  frameDone;
  logic [COUNT_WIDTH-1:0]                rayCount;
  logic                                  genStart;
  logic                                  genBusy;
  logic signed [2:0][POSITION_WIDTH-1:0] genV;
  logic [ADDRESS_WIDTH-1:0]              genAddress;
  logic                                  genValid;
  logic                                  genReady;
  logic                                  genRayBusy;
  logic signed [2:0][POSITION_WIDTH-1:0] unitV;
  logic [ADDRESS_WIDTH-1:0]              unitAddress;
  logic [NUM_UNITS-1:0]                  unitStart;
  logic [NUM_UNITS-1:0]                  unitReady;
  logic [NUM_UNITS-1:0]                  unitBusy;

  modport master (
    input  frameStart, genBusy, genV, genAddress, genValid, unitReady, unitBusy,
    output busy, frameDone, rayCount, genStart, genReady, genRayBusy,
           unitV, unitAddress, unitStart
  );

  modport slave (
    output frameStart, genBusy, genV, genAddress, genValid, unitReady, unitBusy,
    input  busy, frameDone, rayCount, genStart, genReady, genRayBusy,
           unitV, unitAddress, unitStart
  );
endinterface

// File: rtl/ray_dispatcher_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first request at or after ptr, wrapping to the lowest.
module rr_arbiter #(
  parameter  int N  = 4,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx,
  output logic          any
);

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!any && req[i] && (i >= int'(ptr))) begin
        any          = 1'b1;
        grant[i]     = 1'b1;
        grant_idx    = IW'(i);
      end
    end
    // Nothing at or above ptr: wrap around to the lowest requester.
    for (int i = 0; i < N; i++) begin
      if (!any && req[i]) begin
        any          = 1'b1;
        grant[i]     = 1'b1;
        grant_idx    = IW'(i);
      end
    end
  end

endmodule

// File: rtl/ray_dispatcher.sv
// Frame sequencer and round-robin ray distributor between the camera-ray generator and the ray units.
// A one-entry holding register decouples the generator; issue strobe and broadcast ray data are registered.
module ray_dispatcher
  import ray_dispatcher_pkg::*;
#(
  parameter int NUM_UNITS      = NUM_UNITS_DEF,
  parameter int POSITION_WIDTH = POSITION_WIDTH_DEF,
  parameter int ADDRESS_WIDTH  = ADDRESS_WIDTH_DEF,
  parameter int COUNT_WIDTH    = COUNT_WIDTH_DEF
) (
  input logic              clock,
  input logic              reset,
  ray_dispatcher_if.master bus
);
  localparam int PTR_W = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;
  typedef logic signed [2:0][POSITION_WIDTH-1:0] ray_vec_t;

  dispatch_state_e          state_q, state_d;
  logic                     hold_vld_q, hold_vld_d;
  ray_vec_t                 hold_v_q, hold_v_d;
  logic [ADDRESS_WIDTH-1:0] hold_addr_q, hold_addr_d;
  logic [NUM_UNITS-1:0]     unit_start_q, unit_start_d;
  ray_vec_t                 unit_v_q, unit_v_d;
  logic [ADDRESS_WIDTH-1:0] unit_addr_q, unit_addr_d;
  logic [COUNT_WIDTH-1:0]   ray_count_q, ray_count_d;
  logic [PTR_W-1:0]         rr_ptr_q, rr_ptr_d;

  logic [NUM_UNITS-1:0] eligible, grant;
  logic [PTR_W-1:0]     grant_idx;
  logic                 any_eligible, issue, gen_rdy, transfer;

  // A unit strobed this cycle has not yet dropped its ready, so it is masked.
  assign eligible = bus.unitReady & ~unit_start_q;

  rr_arbiter #(.N(NUM_UNITS)) u_arb (
    .req       (eligible),
    .ptr       (rr_ptr_q),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any       (any_eligible)
  );

  assign issue    = hold_vld_q & any_eligible;
  assign gen_rdy  = ~hold_vld_q | issue;
  assign transfer = bus.genValid & gen_rdy;

  always_comb begin
    hold_vld_d   = hold_vld_q;
    hold_v_d     = hold_v_q;
    hold_addr_d  = hold_addr_q;
    unit_start_d = '0;
    unit_v_d     = unit_v_q;
    unit_addr_d  = unit_addr_q;
    ray_count_d  = ray_count_q;
    rr_ptr_d     = rr_ptr_q;
    if (issue) begin
      hold_vld_d   = 1'b0;
      unit_start_d = grant;
      unit_v_d     = hold_v_q;
      unit_addr_d  = hold_addr_q;
      rr_ptr_d     = (int'(grant_idx) == NUM_UNITS - 1) ? '0 : grant_idx + PTR_W'(1);
      if (!(&ray_count_q)) ray_count_d = ray_count_q + COUNT_WIDTH'(1);
    end
    if (transfer) begin
      hold_vld_d  = 1'b1;
      hold_v_d    = bus.genV;
      hold_addr_d = bus.genAddress;
    end
    if (state_q == IDLE && bus.frameStart) ray_count_d = '0;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      hold_vld_q   <= 1'b0;
      hold_v_q     <= '0;
      hold_addr_q  <= '0;
      unit_start_q <= '0;
      unit_v_q     <= '0;
      unit_addr_q  <= '0;
      ray_count_q  <= '0;
      rr_ptr_q     <= '0;
    end else begin
      hold_vld_q   <= hold_vld_d;
      hold_v_q     <= hold_v_d;
      hold_addr_q  <= hold_addr_d;
      unit_start_q <= unit_start_d;
      unit_v_q     <= unit_v_d;
      unit_addr_q  <= unit_addr_d;
      ray_count_q  <= ray_count_d;
      rr_ptr_q     <= rr_ptr_d;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.frameStart) state_d = LAUNCH;
      LAUNCH:  state_d = RUN;
      RUN:     if (!bus.genBusy && !hold_vld_q && (unit_start_q == '0) && (bus.unitBusy == '0))
                 state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.busy      = (state_q != IDLE);
    bus.genStart  = (state_q == LAUNCH);
    bus.frameDone = (state_q == DONE);
  end

  assign bus.rayCount    = ray_count_q;
  assign bus.genReady    = gen_rdy;
  assign bus.genRayBusy  = hold_vld_q | (|unit_start_q) | (|bus.unitBusy);
  assign bus.unitStart   = unit_start_q;
  assign bus.unitV       = unit_v_q;
  assign bus.unitAddress = unit_addr_q;

endmodule
